weight_store: RTL and testbench

- Weight memory responder that serves the network's weight read channel (w_req/w_addr -> w_valid/w_data).
- Also applies reward-driven updates: read-modify-write with a saturating signed 4-bit add on each nibble.
- Has a direct load port for initialisation.
- Sits in TOP between the inference FSM and host/reward logic; it replaces the ad-hoc w_valid generation.

---
 rtl/weight_store.sv | 158 +++++++++++++++
 tb/tb_weight_store.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_store.sv
`default_nettype none
// ============================================================================
// Module   : weight_store
// Brief    : Weight memory with a fixed-latency read channel, a saturating
//            nibble-wise reward-update engine and a direct load port.
// Revision : 1.0 - initial release
// ============================================================================
module weight_store #(
    parameter int             ADDR_W  = 4,
    parameter int             DW      = 8,
    parameter int             RD_LAT  = 1,
    parameter logic [DW-1:0]  RESET_W = {DW{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    output logic              w_valid,
    output logic [DW-1:0]     w_data,
    input  logic              upd_req,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [7:0]        upd_delta,
    output logic              upd_busy,
    output logic              upd_ack,
    output logic              upd_sat,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DW-1:0]     ld_data
);

    localparam int c_DEPTH = 1 << ADDR_W;

    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_CALC  = 2'd1;
    localparam logic [1:0] U_WRITE = 2'd2;
    localparam logic [1:0] U_ACK   = 2'd3;

    logic [DW-1:0]     r_mem [c_DEPTH];
    logic [RD_LAT-1:0] r_vld;
    logic [DW-1:0]     r_dat [RD_LAT];

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_delta;
    logic [DW-1:0]     r_result;
    logic              r_calc_sat;
    logic              r_upd_busy;
    logic              r_upd_ack;
    logic              r_upd_sat;

    logic [DW-1:0]     w_old;
    logic [4:0]        w_sum_hi;
    logic [4:0]        w_sum_lo;
    logic              w_ovf_hi;
    logic              w_ovf_lo;
    logic [3:0]        w_new_hi;
    logic [3:0]        w_new_lo;

    // Sign-extended 5-bit sums; a mismatch of the top two bits means the
    // 4-bit range was exceeded and the sign bit tells which rail to clip to.
    always_comb begin
        w_old    = r_mem[r_addr];
        w_sum_hi = {w_old[7], w_old[7:4]} + {r_delta[7], r_delta[7:4]};
        w_sum_lo = {w_old[3], w_old[3:0]} + {r_delta[3], r_delta[3:0]};
        w_ovf_hi = w_sum_hi[4] ^ w_sum_hi[3];
        w_ovf_lo = w_sum_lo[4] ^ w_sum_lo[3];
        w_new_hi = w_ovf_hi ? (w_sum_hi[4] ? 4'h8 : 4'h7) : w_sum_hi[3:0];
        w_new_lo = w_ovf_lo ? (w_sum_lo[4] ? 4'h8 : 4'h7) : w_sum_lo[3:0];
    end

    // Load is written after the update commit so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= RESET_W;
            end
        end else begin
            if (r_state == U_WRITE) begin
                r_mem[r_addr] <= r_result;
            end
            if (ld_en) begin
                r_mem[ld_addr] <= ld_data;
            end
        end
    end

    // Each data stage only loads when valid so the output holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_req;
            if (w_req) begin
                r_dat[0] <= r_mem[w_addr];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= U_IDLE;
            r_addr     <= '0;
            r_delta    <= '0;
            r_result   <= '0;
            r_calc_sat <= 1'b0;
            r_upd_busy <= 1'b0;
            r_upd_ack  <= 1'b0;
            r_upd_sat  <= 1'b0;
        end else begin
            r_upd_ack <= 1'b0;
            r_upd_sat <= 1'b0;
            case (r_state)
                U_IDLE: begin
                    if (upd_req) begin
                        r_addr     <= upd_addr;
                        r_delta    <= upd_delta;
                        r_upd_busy <= 1'b1;
                        r_state    <= U_CALC;
                    end
                end
                U_CALC: begin
                    r_result   <= {w_new_hi, w_new_lo};
                    r_calc_sat <= w_ovf_hi | w_ovf_lo;
                    r_state    <= U_WRITE;
                end
                U_WRITE: begin
                    r_upd_ack <= 1'b1;
                    r_upd_sat <= r_calc_sat;
                    r_state   <= U_ACK;
                end
                U_ACK: begin
                    r_upd_busy <= 1'b0;
                    r_state    <= U_IDLE;
                end
                default: begin
                    r_state <= U_IDLE;
                end
            endcase
        end
    end

    assign w_valid  = r_vld[RD_LAT-1];
    assign w_data   = r_dat[RD_LAT-1];
    assign upd_busy = r_upd_busy;
    assign upd_ack  = r_upd_ack;
    assign upd_sat  = r_upd_sat;

endmodule
`default_nettype wire

// File: tb/tb_weight_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_store
// Brief    : Scoreboard bench for weight_store: directed scenarios followed by
//            random traffic against a cycle-scheduled behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_store;

    localparam int            ADDR_W  = 4;
    localparam int            DW      = 8;
    localparam int            RD_LAT  = 1;
    localparam logic [DW-1:0] RESET_W = 8'h00;
    localparam int            DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_valid;
    logic [DW-1:0]     w_data;
    logic              upd_req;
    logic [ADDR_W-1:0] upd_addr;
    logic [7:0]        upd_delta;
    logic              upd_busy;
    logic              upd_ack;
    logic              upd_sat;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DW-1:0]     ld_data;

    weight_store #(
        .ADDR_W (ADDR_W),
        .DW     (DW),
        .RD_LAT (RD_LAT),
        .RESET_W(RESET_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_req    (w_req),
        .w_addr   (w_addr),
        .w_valid  (w_valid),
        .w_data   (w_data),
        .upd_req  (upd_req),
        .upd_addr (upd_addr),
        .upd_delta(upd_delta),
        .upd_busy (upd_busy),
        .upd_ack  (upd_ack),
        .upd_sat  (upd_sat),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct { logic [7:0] data; int due; } rd_t;
    typedef struct { bit sat; int due; } ack_t;
    rd_t  rq[$];
    ack_t aq[$];

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents plus the schedule of the one update in flight.
    logic [7:0]  m_mem [DEPTH];
    bit          m_busy = 1'b0;
    int          m_acc;
    logic [3:0]  m_addr;
    logic [7:0]  m_delta;
    logic [7:0]  m_res;

    function automatic int sx4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Returns {clipped, nibble}.
    function automatic logic [4:0] sat_add(input logic [3:0] a, input logic [3:0] d);
        int  s;
        bit  c;
        s = sx4(a) + sx4(d);
        c = 1'b0;
        if (s > 7) begin
            s = 7;
            c = 1'b1;
        end else if (s < -8) begin
            s = -8;
            c = 1'b1;
        end
        return {c, s[3:0]};
    endfunction

    task automatic model_step();
        int         e;
        logic [4:0] hi;
        logic [4:0] lo;
        bit         done;
        e = edge_cnt;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = RESET_W;
            rq.delete();
            aq.delete();
            m_busy = 1'b0;
            return;
        end
        if (w_req) rq.push_back('{data: m_mem[w_addr], due: e + RD_LAT});
        done = 1'b0;
        if (m_busy) begin
            if (e == m_acc + 1) begin
                hi    = sat_add(m_mem[m_addr][7:4], m_delta[7:4]);
                lo    = sat_add(m_mem[m_addr][3:0], m_delta[3:0]);
                m_res = {hi[3:0], lo[3:0]};
                aq.push_back('{sat: hi[4] | lo[4], due: m_acc + 3});
            end
            if (e == m_acc + 2) m_mem[m_addr] = m_res;
            if (e == m_acc + 3) done = 1'b1;
        end else if (upd_req) begin
            m_busy  = 1'b1;
            m_acc   = e;
            m_addr  = upd_addr;
            m_delta = upd_delta;
        end
        if (done) m_busy = 1'b0;
        if (ld_en) m_mem[ld_addr] = ld_data;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
        rst     = 1'b0;
        w_req   = 1'b0;
        upd_req = 1'b0;
        ld_en   = 1'b0;
    endtask

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clk) begin
        rd_t  r;
        ack_t a;
        if (w_valid === 1'b1) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rd_extra cycle=%0d data=%h expected no w_valid", edge_cnt, w_data);
            end else begin
                r = rq.pop_front();
                if (r.due != edge_cnt || w_data !== r.data) begin
                    errors++;
                    $display("FAIL rd_data cycle=%0d data=%h expected cycle=%0d data=%h",
                             edge_cnt, w_data, r.due, r.data);
                end
            end
        end else if (rq.size() > 0 && rq[0].due <= edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL rd_missing cycle=%0d w_valid=%b expected 1 data=%h", edge_cnt, w_valid, rq[0].data);
            r = rq.pop_front();
        end
        if (upd_ack === 1'b1) begin
            checks++;
            if (aq.size() == 0) begin
                errors++;
                $display("FAIL ack_extra cycle=%0d upd_ack=1 expected 0", edge_cnt);
            end else begin
                a = aq.pop_front();
                if (a.due != edge_cnt || upd_sat !== a.sat) begin
                    errors++;
                    $display("FAIL ack cycle=%0d sat=%b expected cycle=%0d sat=%b",
                             edge_cnt, upd_sat, a.due, a.sat);
                end
            end
        end else if (aq.size() > 0 && aq[0].due <= edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL ack_missing cycle=%0d upd_ack=%b expected 1", edge_cnt, upd_ack);
            a = aq.pop_front();
        end
    end

    initial begin
        rst = 1'b1; w_req = 1'b0; w_addr = '0; upd_req = 1'b0; upd_addr = '0;
        upd_delta = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tick();
        rst = 1'b1;
        tick();
        check1("rst_w_valid", {7'd0, w_valid}, 8'h00);
        check1("rst_w_data", w_data, 8'h00);
        check1("rst_upd_busy", {7'd0, upd_busy}, 8'h00);
        check1("rst_upd_ack", {7'd0, upd_ack}, 8'h00);
        check1("rst_upd_sat", {7'd0, upd_sat}, 8'h00);

        for (int a = 0; a < DEPTH; a++) begin
            w_req = 1'b1; w_addr = 4'(a); tick();
        end

        ld_en = 1'b1; ld_addr = 4'h0; ld_data = 8'h2F; tick();
        ld_en = 1'b1; ld_addr = 4'h1; ld_data = 8'h81; tick();
        w_req = 1'b1; w_addr = 4'h0; tick();
        w_req = 1'b1; w_addr = 4'h1; tick();

        // Double clip with sat flag, then a read-back of the result.
        ld_en = 1'b1; ld_addr = 4'h2; ld_data = 8'h6A; tick();
        upd_req = 1'b1; upd_addr = 4'h2; upd_delta = 8'h3B; tick();
        repeat (4) tick();
        w_req = 1'b1; w_addr = 4'h2; tick();

        // Read every cycle across the update to see the old/new boundary.
        ld_en = 1'b1; ld_addr = 4'h3; ld_data = 8'h11; tick();
        upd_req = 1'b1; upd_addr = 4'h3; upd_delta = 8'hF1; w_req = 1'b1; w_addr = 4'h3; tick();
        for (int k = 0; k < 6; k++) begin
            w_req = 1'b1; w_addr = 4'h3;
            if (k == 0) begin
                upd_req = 1'b1; upd_addr = 4'h3; upd_delta = 8'h77;
            end
            tick();
        end

        // Retry while busy is ignored; load in the commit cycle wins.
        ld_en = 1'b1; ld_addr = 4'h4; ld_data = 8'h55; tick();
        upd_req = 1'b1; upd_addr = 4'h4; upd_delta = 8'h11; tick();
        upd_req = 1'b1; upd_addr = 4'h5; upd_delta = 8'h22; tick();
        ld_en = 1'b1; ld_addr = 4'h4; ld_data = 8'hA5; tick();
        repeat (2) tick();
        w_req = 1'b1; w_addr = 4'h4; tick();
        w_req = 1'b1; w_addr = 4'h5; tick();

        // Reset while the update sits in its compute cycle with a read issued.
        ld_en = 1'b1; ld_addr = 4'h5; ld_data = 8'h33; tick();
        upd_req = 1'b1; upd_addr = 4'h5; upd_delta = 8'h11; tick();
        rst = 1'b1; w_req = 1'b1; w_addr = 4'h5; tick();
        check1("rstcalc_upd_busy", {7'd0, upd_busy}, 8'h00);
        check1("rstcalc_w_valid", {7'd0, w_valid}, 8'h00);
        for (int a = 0; a < DEPTH; a++) begin
            w_req = 1'b1; w_addr = 4'(a); tick();
        end

        for (int k = 0; k < 500; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            w_req     = $urandom_range(0, 1) == 1;
            w_addr    = 4'($urandom_range(0, DEPTH - 1));
            upd_req   = ($urandom_range(0, 2) == 0);
            upd_addr  = 4'($urandom_range(0, 3));
            upd_delta = 8'($urandom);
            ld_en     = ($urandom_range(0, 4) == 0);
            ld_addr   = 4'($urandom_range(0, 3));
            ld_data   = 8'($urandom);
            tick();
        end

        repeat (6) tick();
        for (int a = 0; a < DEPTH; a++) begin
            w_req = 1'b1; w_addr = 4'(a); tick();
        end
        repeat (6) tick();

        checks++;
        if (rq.size() != 0 || aq.size() != 0) begin
            errors++;
            $display("FAIL drain pending_reads=%0d pending_acks=%0d expected 0 and 0", rq.size(), aq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
